// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock, LSB first,
// using a single full-subtractor cell. Start/done handshake; result held until
// the next completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_borrow_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow_out
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              br_q, br_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;

    logic a_bit, b_bit, d_bit, br_next, accept;

    // Full-subtractor cell on the current bit position.
    always_comb begin
        a_bit   = a_q[cnt_q];
        b_bit   = b_q[cnt_q];
        d_bit   = a_bit ^ b_bit ^ br_q;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    end

    // Next-state logic: start acceptance, per-bit shift, completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        accept  = 1'b0;

        unique case (state_q)
            StIdle: begin
                accept = i_start;
            end
            StRun: begin
                // New bit enters at the MSB so the first bit lands at bit 0.
                res_d = {d_bit, res_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                accept  = i_start;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            a_d     = i_a;
            b_d     = i_b;
            br_d    = i_borrow_in;
            cnt_d   = '0;
            res_d   = '0;
            state_d = StRun;
        end
    end

    // State registers with synchronous reset; reset aborts any operation.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign o_busy       = (state_q == StRun);
    assign o_done       = (state_q == StDone);
    assign o_diff       = diff_q;
    assign o_borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH = 4).
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_borrow_in;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_diff;
    logic         o_borrow_out;

    int checks = 0;
    int errors = 0;

    // Last completed result the outputs must currently hold.
    logic [W-1:0] held_diff = '0;
    logic         held_bout = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_borrow_in (i_borrow_in),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_diff      (o_diff),
        .o_borrow_out(o_borrow_out)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Idle cycles with i_start low and noisy operands; outputs must hold.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            i_start     = 1'b0;
            i_a         = W'($urandom);
            i_b         = W'($urandom);
            i_borrow_in = 1'($urandom);
            tick();
            check("idle_busy", 32'(o_busy), 32'd0);
            check("idle_done", 32'(o_done), 32'd0);
            check("idle_diff", 32'(o_diff), 32'(held_diff));
            check("idle_bout", 32'(o_borrow_out), 32'(held_bout));
        end
    endtask

    // One operation; returns in the done cycle so a following call starts back-to-back.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] exp_diff, input logic exp_bout,
                          input bit noise);
        i_a         = a;
        i_b         = b;
        i_borrow_in = bin;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < int'(W); k++) begin
            check("run_busy", 32'(o_busy), 32'd1);
            check("run_done", 32'(o_done), 32'd0);
            check("run_diff_held", 32'(o_diff), 32'(held_diff));
            check("run_bout_held", 32'(o_borrow_out), 32'(held_bout));
            if (noise) begin
                i_start     = (k < int'(W) - 1);
                i_a         = ~a;
                i_b         = W'($urandom);
                i_borrow_in = ~bin;
            end
            tick();
        end
        i_start = 1'b0;
        check("done_busy", 32'(o_busy), 32'd0);
        check("done_pulse", 32'(o_done), 32'd1);
        check("done_diff", 32'(o_diff), 32'(exp_diff));
        check("done_bout", 32'(o_borrow_out), 32'(exp_bout));
        held_diff = exp_diff;
        held_bout = exp_bout;
    endtask

    initial begin
        i_reset     = 1'b1;
        i_start     = 1'b1;  // reset must win over start
        i_a         = 4'b1111;
        i_b         = 4'b0000;
        i_borrow_in = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_diff", 32'(o_diff), 32'd0);
        check("rst_bout", 32'(o_borrow_out), 32'd0);
        i_reset = 1'b0;
        i_start = 1'b0;
        idle(1);

        run_op(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        idle(1);
        run_op(4'b1011, 4'b0001, 1'b0, 4'b1010, 1'b0, 1'b0);
        idle(2);
        run_op(4'b1101, 4'b0000, 1'b1, 4'b1100, 1'b0, 1'b0);
        idle(1);

        // Underflow cases, issued back-to-back from the done cycle.
        run_op(4'b0000, 4'b1010, 1'b1, 4'b0101, 1'b1, 1'b0);
        run_op(4'b0011, 4'b1100, 1'b0, 4'b0111, 1'b1, 1'b0);
        run_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
        idle(1);

        // Start and operand changes while busy must be ignored.
        run_op(4'b1000, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b1);
        idle(2);

        // Reset after two RUN cycles aborts with no done pulse.
        i_a         = 4'b1111;
        i_b         = 4'b0001;
        i_borrow_in = 1'b0;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        check("mid_busy", 32'(o_busy), 32'd1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_diff", 32'(o_diff), 32'd0);
        check("abort_bout", 32'(o_borrow_out), 32'd0);
        held_diff = '0;
        held_bout = 1'b0;
        idle(6);
        run_op(4'b0111, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0);

        // Hold across a long idle with changing inputs.
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor, the inverse operation to the team's ripple-carry adder: computes i_a - i_b - i_borrow_in one bit per clock, LSB first, reusing a single full-subtractor cell.
- Trades area for latency; used where a WIDTH-bit ripple chain is too large.
- Start/done handshake toward the controlling logic; result and borrow are registered and held until the next completion.

Parameters:
WIDTH, 4, operand/result width in bits (>= 2)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_reset  input  1  synchronous reset, active-high
i_start  input  1  request; sampled only when not busy
i_a  input  WIDTH  minuend, sampled on accepted start
i_b  input  WIDTH  subtrahend, sampled on accepted start
i_borrow_in  input  1  initial borrow, sampled on accepted start
o_busy  output  1  high while bits are being processed
o_done  output  1  one-cycle pulse: o_diff/o_borrow_out just updated
o_diff  output  WIDTH  difference modulo 2^WIDTH
o_borrow_out  output  1  final borrow (1 = result negative / underflow)

Behaviour:
- One clock, synchronous active-high reset, as fixed above.
- Reset (any state, including mid-operation): state IDLE, o_busy=0, o_done=0, o_diff=0, o_borrow_out=0. Internal operand, partial-result, borrow and counter registers are cleared. An operation in progress is aborted with no done pulse.
- FSM states: IDLE, RUN, DONE.
- Start is accepted in IDLE or DONE when i_start=1. On the accepting edge:
  - latch i_a, i_b and i_borrow_in into internal registers;
  - bit counter = 0;
  - state -> RUN, o_busy -> 1, o_done -> 0.
- RUN: each edge processes bit k = counter.
  - d = a[k] ^ b[k] ^ br
  - br_next = (~a[k] & b[k]) | (~(a[k] ^ b[k]) & br)
  - d shifts into the internal partial-result register (MSB-in shift, LSB ends at bit 0); counter increments.
- Last bit (counter == WIDTH-1), on that edge:
  - o_diff <= completed result, o_borrow_out <= br_next;
  - o_done <= 1, o_busy <= 0, state -> DONE.
- DONE lasts one cycle. With no start, next edge: state -> IDLE, o_done -> 0.
- Latency: start accepted at edge t. o_busy is high for exactly WIDTH cycles (edges t..t+WIDTH). o_done is high for the one cycle after edge t+WIDTH. Throughput is one operation per WIDTH+1 cycles; back-to-back is allowed by starting in the DONE cycle, which skips IDLE.
- i_start while o_busy=1 is ignored, with no queuing and no effect on the running operation.
- i_a, i_b and i_borrow_in are don't-care except on the accepting edge; changes during RUN must not alter the result.
- o_diff and o_borrow_out change only on the completing edge or on reset. Partial results are never visible and outputs are held indefinitely in IDLE.
- Result equals (a - b - borrow_in) mod 2^WIDTH. o_borrow_out = 1 iff a < b + borrow_in (unsigned).
- Reset asserted together with i_start: reset wins, start is ignored.

Test Plan:
- Reset, then a=0000 b=0000 bin=0 -> after 4 busy cycles: done pulse, diff=0000, bout=0.
- a=1011 b=0001 bin=0 -> diff=1010, bout=0. Then a=1101 b=0000 bin=1 -> diff=1100, bout=0.
- Underflow cases:
  - a=0000 b=1010 bin=1 -> diff=0101, bout=1;
  - a=0011 b=1100 bin=0 -> diff=0111, bout=1;
  - a=1111 b=1111 bin=1 -> diff=1111, bout=1.
- Timing: o_busy high exactly 4 cycles and o_done high exactly 1 cycle.
  - Start re-asserted during the busy cycles and i_a/i_b toggled -> ignored, result unchanged.
  - Start in the DONE cycle -> new operation begins immediately.
- Reset after 2 RUN cycles -> all outputs 0, no done pulse. A following start of a=0111 b=0010 bin=0 -> diff=0101, bout=0.
- Outputs hold: after completion, idle 10 cycles with changing inputs and i_start=0 -> o_diff/o_borrow_out unchanged, o_done stays 0.
